param_padlock: RTL and testbench
================================

PARAM_PADLOCK -- requirements
Module: param_padlock

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 4: number of keypad buttons, >=2; digit width DW = clog2(NUM_BUTTONS).
REQ-002 SHALL have parameter CODE_LEN, default 4: digits per code, 1..16.
REQ-003 SHALL have parameter DEFAULT_CODE, default {2,1,3,0} packed digit0-first in LSBs, width CODE_LEN*DW: code after reset.
REQ-004 SHALL have parameter MAX_FAILS, default 3: consecutive wrong codes that trigger lockout, >=1.
REQ-005 SHALL have parameter LOCKOUT_CYCLES, default 1000: lockout duration in clk cycles, >=1.
REQ-006 SHALL have parameter UNLOCK_CYCLES, default 5000: auto-relock timeout in clk cycles, >=1.
REQ-007 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port buttons, input, NUM_BUTTONS: synchronised, debounced button levels, bit i = button i.
REQ-010 SHALL have port relock, input, 1: level; forces UNLOCKED to LOCKED.
REQ-011 SHALL have port lock, output, 1: registered; 1 = locked.
REQ-012 SHALL have port lockout, output, 1: registered; 1 = LOCKOUT state.
REQ-013 SHALL have port fail_count, output, clog2(MAX_FAILS+1): registered consecutive wrong-code count.

Function
REQ-014 SHALL register buttons each cycle; a press SHALL be a cycle where buttons != 0 and previous sample == 0; held or additional buttons while any is held SHALL not create presses.
REQ-015 SHALL encode a press with exactly one bit set as that bit's index; a press with more than one bit set SHALL be stored as an invalid digit that never matches.
REQ-016 SHALL implement states LOCKED, UNLOCKED, LOCKOUT; lock=0 only in UNLOCKED; lockout=1 only in LOCKOUT.
REQ-017 In LOCKED, each press SHALL store the digit at index idx and increment idx (0..CODE_LEN-1).
REQ-018 On the press completing CODE_LEN digits, the full entry including that digit SHALL be compared with the stored code on the same edge; match -> UNLOCKED, lock=0 in the following cycle, fail_count cleared, idx=0.
REQ-019 On mismatch, idx SHALL return to 0 and fail_count SHALL increment; if the new value equals MAX_FAILS, the state SHALL become LOCKOUT.
REQ-020 In LOCKOUT, presses SHALL be ignored and not counted; after exactly LOCKOUT_CYCLES cycles, the state SHALL return to LOCKED with fail_count=0 and idx=0.
REQ-021 In UNLOCKED, a timer SHALL count UNLOCK_CYCLES cycles and then return to LOCKED; relock=1 SHALL return to LOCKED on the next edge; on either exit idx=0.
REQ-022 In UNLOCKED, presses SHALL not affect idx or the code, except as given in REQ-027.
REQ-023 Timers SHALL be sized clog2(max(LOCKOUT_CYCLES, UNLOCK_CYCLES)+1) and SHALL never wrap.

Reset
REQ-024 reset SHALL override everything: state LOCKED, lock=1, lockout=0, fail_count=0, idx=0, timers=0, button sample=0, code=DEFAULT_CODE. This applies in any state, including mid-entry and mid-lockout.
REQ-025 The first cycle after reset with buttons != 0 SHALL count as a press.

Configuration
REQ-026 Macro PADLOCK_CODE_CHANGE_EN SHALL add input port program (1 bit).
REQ-027 With the macro defined: in UNLOCKED with program=1, presses SHALL fill a new-code buffer; the timer SHALL hold. After CODE_LEN valid presses, the stored code SHALL update and the state SHALL become LOCKED. An invalid press or program dropping early SHALL discard the buffer and leave the code unchanged.
REQ-028 Without the macro, the program port SHALL be absent, the code SHALL be constant DEFAULT_CODE, and REQ-027 logic SHALL not be present.

Verification
REQ-029 Defaults; after reset, press 2,1,3,0 with gaps -> lock=0 one cycle after the edge sampling the 0 press; fail_count=0.
REQ-030 Press 0,0,0,0 three times -> fail_count 1,2, then lockout=1; presses during lockout are ignored; lockout=0 after exactly 1000 cycles; then 2,1,3,0 unlocks.
REQ-031 Unlock, then idle -> lock=1 after exactly 5000 cycles; a separate unlock followed by relock=1 -> lock=1 on the next cycle.
REQ-032 Press buttons=4'b0110, then 1,3,0 -> counted as a fail; a held button across 10 cycles -> a single digit.
REQ-033 Reset asserted mid-entry (2 digits) and mid-lockout -> all REQ-024 values hold; the next full correct code unlocks.
REQ-034 With PADLOCK_CODE_CHANGE_EN: unlock, program=1, press 3,3,1,0 -> lock=1; 2,1,3,0 fails; 3,3,1,0 unlocks; reset restores 2,1,3,0.

Source files
------------

// File: rtl/param_padlock.sv
// param_padlock: keypad combination lock with fail lockout and auto-relock; PADLOCK_CODE_CHANGE_EN adds in-place code reprogramming.
// Latency: a press is decoded and acted on at the edge that samples it; lock/lockout/fail_count update on that same edge.
// Backpressure: none; presses in LOCKOUT, while a button is held, or while UNLOCKED (outside programming) are dropped.
module param_padlock #(
   parameter int NUM_BUTTONS    = 4,
   parameter int CODE_LEN       = 4,
   parameter logic [CODE_LEN*$clog2(NUM_BUTTONS)-1:0] DEFAULT_CODE = {2'd0, 2'd3, 2'd1, 2'd2},
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int UNLOCK_CYCLES  = 5000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_BUTTONS-1:0]           buttons,
   input  logic                             relock,
`ifdef PADLOCK_CODE_CHANGE_EN
   // "program" is a reserved word, so the reprogram enable is program_en
   input  logic                             program_en,
`endif
   output logic                             lock,
   output logic                             lockout,
   output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

   localparam int DW    = $clog2(NUM_BUTTONS);
   localparam int CW    = CODE_LEN * DW;
   localparam int IW    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int FW    = $clog2(MAX_FAILS + 1);
   localparam int MAX_T = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
   localparam int TW    = $clog2(MAX_T + 1);

   typedef enum logic [1:0] {
      LOCKED   = 2'd0,
      UNLOCKED = 2'd1,
      LOCKOUT  = 2'd2
   } state_t;

   state_t                 state, state_nxt;
   logic [NUM_BUTTONS-1:0] btn_q;
   logic [IW-1:0]          idx, idx_nxt;
   logic [CW-1:0]          entry, entry_nxt, full_entry;
   logic                   entry_bad, entry_bad_nxt;
   logic [FW-1:0]          fail_nxt;
   logic [TW-1:0]          timer, timer_nxt;
   logic                   lock_nxt, lockout_nxt;
   logic                   press, press_ok, match;
   logic [DW-1:0]          digit;
   logic [CW-1:0]          code;

`ifdef PADLOCK_CODE_CHANGE_EN
   logic [CW-1:0]          code_nxt;
   logic [CW-1:0]          new_code, new_code_nxt, new_full;
   logic [IW-1:0]          pidx, pidx_nxt;
`else
   localparam logic [CW-1:0] FIXED_CODE = DEFAULT_CODE;
   assign code = FIXED_CODE;
`endif

   // Press = rising edge of "any button"; multi-bit presses are kept but flagged as invalid.
   always_comb begin
      press    = (buttons != '0) && (btn_q == '0);
      press_ok = (buttons & (buttons - NUM_BUTTONS'(1))) == '0;
      digit    = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (buttons[i]) digit = DW'(i);
      end
   end

   always_comb begin
      full_entry                  = entry;
      full_entry[idx*DW +: DW]    = digit;
      match = !entry_bad && press_ok && (full_entry == code);
   end

`ifdef PADLOCK_CODE_CHANGE_EN
   always_comb begin
      new_full                 = new_code;
      new_full[pidx*DW +: DW]  = digit;
   end
`endif

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      entry_nxt     = entry;
      entry_bad_nxt = entry_bad;
      fail_nxt      = fail_count;
      timer_nxt     = timer;
`ifdef PADLOCK_CODE_CHANGE_EN
      code_nxt      = code;
      new_code_nxt  = new_code;
      // Buffer survives only while programming stays asserted in UNLOCKED
      pidx_nxt      = (state == UNLOCKED && program_en) ? pidx : '0;
`endif

      case (state)
         LOCKED: begin
            if (press) begin
               if (idx == IW'(CODE_LEN - 1)) begin
                  idx_nxt       = '0;
                  entry_nxt     = '0;
                  entry_bad_nxt = 1'b0;
                  if (match) begin
                     state_nxt = UNLOCKED;
                     fail_nxt  = '0;
                     timer_nxt = '0;
                  end else begin
                     fail_nxt = fail_count + FW'(1);
                     if (fail_nxt == FW'(MAX_FAILS)) begin
                        state_nxt = LOCKOUT;
                        timer_nxt = '0;
                     end
                  end
               end else begin
                  entry_nxt     = full_entry;
                  entry_bad_nxt = entry_bad | ~press_ok;
                  idx_nxt       = idx + IW'(1);
               end
            end
         end

         LOCKOUT: begin
            if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
               state_nxt = LOCKED;
               fail_nxt  = '0;
               idx_nxt   = '0;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end

         UNLOCKED: begin
            if (relock) begin
               state_nxt = LOCKED;
               idx_nxt   = '0;
               timer_nxt = '0;
            end
`ifdef PADLOCK_CODE_CHANGE_EN
            else if (program_en) begin
               // Relock timer is frozen while a new code is being keyed in
               if (press) begin
                  if (!press_ok) begin
                     pidx_nxt = '0;
                  end else if (pidx == IW'(CODE_LEN - 1)) begin
                     code_nxt  = new_full;
                     pidx_nxt  = '0;
                     state_nxt = LOCKED;
                     idx_nxt   = '0;
                     timer_nxt = '0;
                  end else begin
                     new_code_nxt = new_full;
                     pidx_nxt     = pidx + IW'(1);
                  end
               end
            end
`endif
            else if (timer == TW'(UNLOCK_CYCLES - 1)) begin
               state_nxt = LOCKED;
               idx_nxt   = '0;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end

         default: begin
            state_nxt = LOCKED;
            idx_nxt   = '0;
            timer_nxt = '0;
         end
      endcase

      lock_nxt    = (state_nxt != UNLOCKED);
      lockout_nxt = (state_nxt == LOCKOUT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LOCKED;
         btn_q      <= '0;
         idx        <= '0;
         entry      <= '0;
         entry_bad  <= 1'b0;
         fail_count <= '0;
         timer      <= '0;
         lock       <= 1'b1;
         lockout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         btn_q      <= buttons;
         idx        <= idx_nxt;
         entry      <= entry_nxt;
         entry_bad  <= entry_bad_nxt;
         fail_count <= fail_nxt;
         timer      <= timer_nxt;
         lock       <= lock_nxt;
         lockout    <= lockout_nxt;
      end
   end

`ifdef PADLOCK_CODE_CHANGE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         code     <= DEFAULT_CODE;
         new_code <= '0;
         pidx     <= '0;
      end else begin
         code     <= code_nxt;
         new_code <= new_code_nxt;
         pidx     <= pidx_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_param_padlock.sv
// Directed bench for param_padlock (default parameters); expectations are queued
// when a step is driven and popped when the outputs are sampled after the edge.
module tb_param_padlock;

   localparam int LOCKOUT_CYCLES = 1000;
   localparam int UNLOCK_CYCLES  = 5000;

   // Expected {lock, lockout, fail_count[1:0]}
   localparam logic [3:0] L0 = 4'b1000;
   localparam logic [3:0] L1 = 4'b1001;
   localparam logic [3:0] L2 = 4'b1010;
   localparam logic [3:0] LO = 4'b1111;
   localparam logic [3:0] UN = 4'b0000;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] buttons;
   logic       relock;
   logic       lock;
   logic       lockout;
   logic [1:0] fail_count;
`ifdef PADLOCK_CODE_CHANGE_EN
   logic       program_en;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_chk_cyc = 0;
   int t0;

   logic [3:0] exp_q[$];
   string      tag_q[$];

   param_padlock dut (
      .clk        (clk),
      .reset      (reset),
      .buttons    (buttons),
      .relock     (relock),
`ifdef PADLOCK_CODE_CHANGE_EN
      .program_en (program_en),
`endif
      .lock       (lock),
      .lockout    (lockout),
      .fail_count (fail_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic expect_out(input string t, input logic [3:0] e);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic check_out();
      logic [3:0] e;
      string t;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty observed 0 entries required 1");
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         last_chk_cyc = cyc;
         checks++;
         assert (lock === e[3]) else begin
            errors++;
            $error("FAIL %s lock observed %b expected %b", t, lock, e[3]);
         end
         checks++;
         assert (lockout === e[2]) else begin
            errors++;
            $error("FAIL %s lockout observed %b expected %b", t, lockout, e[2]);
         end
         checks++;
         assert (fail_count === e[1:0]) else begin
            errors++;
            $error("FAIL %s fail_count observed %0d expected %0d", t, fail_count, e[1:0]);
         end
      end
   endtask

   task automatic press_raw(input logic [3:0] v, input string t, input logic [3:0] e);
      buttons = v;
      expect_out(t, e);
      step();
      check_out();
      buttons = '0;
      step();
   endtask

   task automatic press(input int d, input string t, input logic [3:0] e);
      logic [3:0] v;
      v = '0;
      v[d] = 1'b1;
      press_raw(v, t, e);
   endtask

   task automatic enter_code(input int d0, input int d1, input int d2, input int d3,
                             input string t, input logic [3:0] mid, input logic [3:0] fin);
      press(d0, {t, "_d0"}, mid);
      step();
      press(d1, {t, "_d1"}, mid);
      step();
      press(d2, {t, "_d2"}, mid);
      step();
      press(d3, {t, "_d3"}, fin);
   endtask

   task automatic do_relock(input string t);
      relock = 1'b1;
      expect_out(t, L0);
      step();
      check_out();
      relock = 1'b0;
      step();
   endtask

   task automatic do_reset(input string t);
      reset = 1'b1;
      expect_out(t, L0);
      step();
      check_out();
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      buttons = '0;
      relock  = 1'b0;
`ifdef PADLOCK_CODE_CHANGE_EN
      program_en = 1'b0;
`endif
      step();
      do_reset("reset");
      expect_out("idle", L0);
      step();
      check_out();

      // Correct default code unlocks on the edge sampling the last digit
      enter_code(2, 1, 3, 0, "open", L0, UN);
      do_relock("relock");

      // Three wrong codes -> lockout
      enter_code(0, 0, 0, 0, "fail1", L0, L1);
      enter_code(0, 0, 0, 0, "fail2", L1, L2);
      enter_code(0, 0, 0, 0, "fail3", L2, LO);
      t0 = last_chk_cyc;
      enter_code(2, 1, 3, 0, "lo_ign", LO, LO);
      while (cyc < t0 + LOCKOUT_CYCLES - 1) step();
      expect_out("lo_last", LO);
      check_out();
      expect_out("lo_end", L0);
      step();
      check_out();
      enter_code(2, 1, 3, 0, "post_lo", L0, UN);

      // Auto-relock timing
      t0 = last_chk_cyc;
      while (cyc < t0 + UNLOCK_CYCLES - 1) step();
      expect_out("un_last", UN);
      check_out();
      expect_out("auto_relock", L0);
      step();
      check_out();

      // Multi-button press is an invalid digit
      press_raw(4'b0110, "multi_d0", L0);
      press(1, "multi_d1", L0);
      press(3, "multi_d2", L0);
      press(0, "multi_d3", L1);

      // Held button, then an extra button while held: still one digit
      buttons = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         expect_out("hold", L1);
         step();
         check_out();
      end
      buttons = 4'b0110;
      for (int i = 0; i < 5; i++) begin
         expect_out("hold_extra", L1);
         step();
         check_out();
      end
      buttons = '0;
      step();
      press(1, "hold_d1", L1);
      press(3, "hold_d2", L1);
      press(0, "hold_d3", UN);
      do_relock("relock2");

      // Reset mid-entry; button held through reset is a press afterwards
      press(2, "mid_d0", L0);
      press(1, "mid_d1", L0);
      buttons = 4'b0100;
      do_reset("rst_entry");
      expect_out("first_press", L0);
      step();
      check_out();
      buttons = '0;
      step();
      press(1, "after_rst_d1", L0);
      press(3, "after_rst_d2", L0);
      press(0, "after_rst_d3", UN);
      do_relock("relock3");

      // Reset mid-lockout
      enter_code(1, 1, 1, 1, "lf1", L0, L1);
      enter_code(1, 1, 1, 1, "lf2", L1, L2);
      enter_code(1, 1, 1, 1, "lf3", L2, LO);
      repeat (20) step();
      do_reset("rst_lockout");
      expect_out("rst_lockout_idle", L0);
      step();
      check_out();
      enter_code(0, 0, 0, 0, "post_rst_fail", L0, L1);
      enter_code(2, 1, 3, 0, "post_rst_open", L1, UN);
      do_relock("relock4");

`ifdef PADLOCK_CODE_CHANGE_EN
      enter_code(2, 1, 3, 0, "pg_open", L0, UN);
      program_en = 1'b1;
      enter_code(3, 3, 1, 0, "pg_new", UN, L0);
      program_en = 1'b0;
      step();
      enter_code(2, 1, 3, 0, "pg_old", L0, L1);
      enter_code(3, 3, 1, 0, "pg_use", L1, UN);
      do_relock("pg_relock");
      do_reset("pg_reset");
      step();
      enter_code(2, 1, 3, 0, "pg_restored", L0, UN);
`endif

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_leftover observed %0d required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
